// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the configurable UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [1:0] {
        BITS_5 = 2'b00,
        BITS_6 = 2'b01,
        BITS_7 = 2'b10,
        BITS_8 = 2'b11
    } data_bits_e;

    // The bit period lives beside this struct because its width is a top-level parameter.
    typedef struct packed {
        data_bits_e data_bits;
        parity_e    parity;
        logic       stop2;
    } cfg_t;

    function automatic logic [3:0] data_bits_n(input logic [1:0] enc);
        return 4'd5 + {2'b00, enc};
    endfunction

    function automatic logic [2:0] last_bit_idx(input logic [1:0] enc);
        return {1'b1, enc};
    endfunction

    function automatic parity_e decode_parity(input logic [1:0] p);
        case (p)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] enc,
                                         input parity_e p);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(data_bits_n(enc))) x = x ^ d[i];
        end
        return (p == PAR_ODD) ? ~x : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous byte FIFO with full/empty flags and occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [7:0]       data_i,
    input  logic             pop_i,
    output logic [7:0]       data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + LVL_W'(1);
            else if (!do_push && do_pop) count_q <= count_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ext.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ext
//  Description : Runtime-configurable UART transmitter (5-8 bits, parity, 1/2 stop) with TX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DIV_W-1:0] div_i,
    input  logic [1:0]       data_bits_i,
    input  logic [1:0]       parity_i,
    input  logic             stop2_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic [LVL_W-1:0] level_o
);

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             push;
    logic             load;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    cfg_t             cfg_q, cfg_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic [2:0]       bit_nxt;

    assign ready_o = !fifo_full;
    assign push    = valid_i && ready_o;
    assign busy_o  = (state_q != IDLE);
    assign tx_o    = tx_q;
    assign bit_end = (cnt_q == div_q - DIV_W'(1));
    assign bit_nxt = bit_q + 3'd1;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (data_i),
        .pop_i   (load),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(1);
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            cfg_q   <= '{data_bits: BITS_8, parity: PAR_NONE, stop2: 1'b0};
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cfg_q   <= cfg_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level of the state being entered, so tx_o lines up with state_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        div_d   = div_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        cfg_d   = cfg_q;
        tx_d    = tx_q;
        load    = 1'b0;

        if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == last_bit_idx(cfg_q.data_bits)) begin
                        if (cfg_q.parity != PAR_NONE) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = shift_q[bit_nxt];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (cfg_q.stop2 && !stop_q) stop_d = 1'b1;
                    else if (!fifo_empty)       load   = 1'b1;
                    else                        state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: pop the head word and snapshot the configuration.
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            tx_d    = 1'b0;
            div_d   = (div_i == '0) ? DIV_W'(1) : div_i;
            cfg_d   = '{data_bits: data_bits_e'(data_bits_i),
                        parity:    decode_parity(parity_i),
                        stop2:     stop2_i};
            shift_d = fifo_rdata;
            par_d   = calc_parity(fifo_rdata, data_bits_i, decode_parity(parity_i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ext
//  Description : Randomised self-checking bench with a cycle-level line model for uart_tx_ext.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ext;

    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       data = '0;
    logic             valid = 1'b0;
    logic             ready;
    logic [DIV_W-1:0] div = DIV_W'(1);
    logic [1:0]       dbits = 2'b11;
    logic [1:0]       par = 2'b00;
    logic             stop2 = 1'b0;
    logic             tx;
    logic             busy;
    logic [LVL_W-1:0] level;

    uart_tx_ext #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data),
        .valid_i     (valid),
        .ready_o     (ready),
        .div_i       (div),
        .data_bits_i (dbits),
        .parity_i    (par),
        .stop2_i     (stop2),
        .tx_o        (tx),
        .busy_o      (busy),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         pc;
    } item_t;

    item_t mq[$];
    bit    exp_q[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    logic [DIV_W-1:0] p_div = DIV_W'(1);
    logic [1:0]       p_dbits = 2'b11;
    logic [1:0]       p_par = 2'b00;
    logic             p_stop2 = 1'b0;
    logic             p_rst = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected line levels for one frame, one entry per clock cycle.
    task automatic build_frame(input logic [7:0] d);
        int n;
        int de;
        bit bits[$];
        bit pb;
        n  = 5 + int'(p_dbits);
        de = (p_div == 0) ? 1 : int'(p_div);
        pb = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            pb = pb ^ d[i];
        end
        if (p_par == 2'b01) bits.push_back(pb);
        if (p_par == 2'b10) bits.push_back(~pb);
        bits.push_back(1'b1);
        if (p_stop2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (de) exp_q.push_back(bits[i]);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        int lvl;
        bit etx;
        bit ebusy;
        @(negedge clk);
        if (p_rst) begin
            mq.delete();
            exp_q.delete();
        end else if (exp_q.size() == 0 && mq.size() > 0 && mq[0].pc <= cyc - 2) begin
            build_frame(mq[0].d);
            void'(mq.pop_front());
        end
        etx   = 1'b1;
        ebusy = 1'b0;
        if (exp_q.size() > 0) begin
            etx   = exp_q.pop_front();
            ebusy = 1'b1;
        end
        lvl = 0;
        foreach (mq[i]) if (mq[i].pc < cyc) lvl++;
        check("tx_o", 32'(tx), 32'(etx));
        check("busy_o", 32'(busy), 32'(ebusy));
        check("level_o", 32'(level), 32'(lvl));
        check("ready_o", 32'(ready), 32'(lvl < FIFO_DEPTH));
        p_div   = div;
        p_dbits = dbits;
        p_par   = par;
        p_stop2 = stop2;
        p_rst   = rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int dv, input int db, input int pr, input int s2);
        div   = DIV_W'(dv);
        dbits = 2'(db);
        par   = 2'(pr);
        stop2 = 1'(s2);
    endtask

    task automatic push(input logic [7:0] d);
        int w;
        w     = 0;
        valid = 1'b1;
        data  = d;
        while (ready !== 1'b1 && w < 5000) begin
            tick(1);
            w++;
        end
        if (ready !== 1'b1) check("push_ready", 32'(ready), 32'd1);
        else mq.push_back('{d, cyc});
        tick(1);
        valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int w;
        w = 0;
        while ((mq.size() > 0 || exp_q.size() > 0) && w < budget) begin
            tick(1);
            w++;
        end
        tick(1);
        check("idle_after_drain", 32'(busy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);

        // 8N1 div=4, 7E2 div=3, 5O1 div=1
        set_cfg(4, 3, 0, 0); push(8'hA5); wait_drain(200);
        set_cfg(3, 2, 1, 1); push(8'h41); wait_drain(200);
        set_cfg(1, 0, 2, 0); push(8'hFF); wait_drain(200);
        set_cfg(0, 1, 1, 0); push(8'h2C); wait_drain(200);

        // Keep the FSM busy and overfill the FIFO
        set_cfg(20, 3, 0, 0);
        push(8'h11);
        for (int i = 0; i < 9; i++) push(8'($urandom));
        wait_drain(5000);

        // Configuration change mid-frame applies to the next frame only
        set_cfg(3, 3, 1, 0);
        push(8'h5A);
        push(8'hC3);
        tick(8);
        set_cfg(5, 2, 2, 1);
        wait_drain(1000);

        // Reset in DATA with three words queued
        set_cfg(4, 3, 0, 0);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(80);
        check("post_reset_level", 32'(level), 32'd0);

        // Random traffic with configuration changes at arbitrary times
        for (int it = 0; it < 40; it++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                push(8'($urandom));
                tick($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0)
                    set_cfg($urandom_range(0, 4), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 1));
            end
            if ($urandom_range(0, 1) == 0) wait_drain(2000);
        end
        wait_drain(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
